// File: rtl/character_reader_if.sv
// Frame-request, text-RAM read and character-stream signals of the character reader.
// master = the reader, slave = the RAM/downstream side.
interface character_reader_if;
  logic       frame_start;
  logic       busy;
  logic       read_enable;
  logic [4:0] read_row;
  logic [6:0] read_col;
  logic [7:0] read_byte;
  logic       character_ready;
  logic       character_valid;
  logic [7:0] character_byte;
  logic [4:0] character_row;
  logic [6:0] character_col;
  logic       character_last;

  modport master (
    input  frame_start, read_byte, character_ready,
    output busy, read_enable, read_row, read_col,
           character_valid, character_byte, character_row, character_col, character_last
  );

  modport slave (
    output frame_start, read_byte, character_ready,
    input  busy, read_enable, read_row, read_col,
           character_valid, character_byte, character_row, character_col, character_last
  );
endinterface

// File: rtl/character_reader.sv
// Walks the text RAM in raster order once per frame request and streams each byte,
// tagged with row/col, through a 2-entry credit-tracked output buffer.
module character_reader #(
  parameter int ROWS = 30,
  parameter int COLS = 100
) (
  input logic               clk,
  input logic               reset,
  character_reader_if.master bus
);

  localparam int DATA_W = 8;
  localparam logic [4:0] ROW_MAX = 5'(ROWS - 1);
  localparam logic [6:0] COL_MAX = 7'(COLS - 1);

  typedef enum logic [1:0] {IDLE, READING, DRAINING} state_t;

  state_t            state;
  logic [4:0]        row_p0;
  logic [6:0]        col_p0;
  logic              vld_p1;
  logic [4:0]        row_p1;
  logic [6:0]        col_p1;
  logic              last_p1;
  logic [1:0]        occ;
  logic [1:0]        occ_nxt;
  logic [DATA_W-1:0] spare_byte;
  logic [4:0]        spare_row;
  logic [6:0]        spare_col;
  logic              spare_last;

  logic pop;
  logic push;
  logic credit;
  logic issue;
  logic at_end;

  assign pop    = bus.character_valid & bus.character_ready;
  assign push   = vld_p1;
  // A slot is free if the buffer plus the read in flight leave room, counting this cycle's pop.
  assign credit = (3'(occ) + 3'(vld_p1)) < (3'd2 + 3'(pop));
  assign issue  = (state == READING) && credit;
  assign at_end = (row_p0 == ROW_MAX) && (col_p0 == COL_MAX);

  assign bus.read_enable = issue;
  assign bus.read_row    = row_p0;
  assign bus.read_col    = col_p0;
  assign bus.busy        = (state != IDLE);

  always_comb begin
    occ_nxt = occ + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      row_p0              <= '0;
      col_p0              <= '0;
      vld_p1              <= 1'b0;
      occ                 <= '0;
      bus.character_valid <= 1'b0;
      bus.character_last  <= 1'b0;
      bus.character_byte  <= '0;
      bus.character_row   <= '0;
      bus.character_col   <= '0;
    end else begin
      // p0: address generation
      case (state)
        IDLE: begin
          if (bus.frame_start) begin
            state  <= READING;
            row_p0 <= '0;
            col_p0 <= '0;
          end
        end
        READING: begin
          if (issue) begin
            if (at_end) state <= DRAINING;
            if (col_p0 == COL_MAX) begin
              col_p0 <= '0;
              row_p0 <= row_p0 + 5'd1;
            end else begin
              col_p0 <= col_p0 + 7'd1;
            end
          end
        end
        DRAINING: begin
          if (pop && bus.character_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // p1: read in flight, tags travel with it
      vld_p1 <= issue;
      if (issue) begin
        row_p1  <= row_p0;
        col_p1  <= col_p0;
        last_p1 <= at_end;
      end

      // p2: output buffer, head is the registered output
      occ                 <= occ_nxt;
      bus.character_valid <= (occ_nxt != 2'd0);
      if (push && ((occ == 2'd0) || ((occ == 2'd1) && pop))) begin
        bus.character_byte <= bus.read_byte;
        bus.character_row  <= row_p1;
        bus.character_col  <= col_p1;
        bus.character_last <= last_p1;
      end else if ((occ == 2'd2) && pop) begin
        bus.character_byte <= spare_byte;
        bus.character_row  <= spare_row;
        bus.character_col  <= spare_col;
        bus.character_last <= spare_last;
      end
      if (push && (((occ == 2'd1) && !pop) || ((occ == 2'd2) && pop))) begin
        spare_byte <= bus.read_byte;
        spare_row  <= row_p1;
        spare_col  <= col_p1;
        spare_last <= last_p1;
      end
    end
  end

endmodule

// File: doc/character_reader.md
Name: character_reader

Overview:
- Read-side counterpart to the character write path into the text buffer.
- On a frame request, it walks the text RAM in raster order: row 0..ROWS-1, col 0..COLS-1.
- It issues 1-cycle-latency RAM reads and streams each byte out on a valid/ready interface, tagged with row/col, toward the glyph/video pipeline.
- A 2-entry output buffer with credit tracking sustains 1 char/cycle under backpressure.

Parameters:
ROWS, 30, rows per frame (1..32)
COLS, 100, columns per row (1..128)

Ports:
clk  input  1  clock
reset  input  1  synchronous reset, active-high
frame_start  input  1  single-cycle request to begin a frame pass; ignored unless idle
busy  output  1  high from the cycle after an accepted frame_start until the last character handshake completes
read_enable  output  1  RAM read strobe
read_row  output  5  RAM row address
read_col  output  7  RAM column address
read_byte  input  8  RAM data, valid exactly 1 cycle after read_enable
character_ready  input  1  downstream ready
character_valid  output  1  output character valid
character_byte  output  8  character data
character_row  output  5  row of character
character_col  output  7  column of character
character_last  output  1  high with the final character of the frame (ROWS-1, COLS-1)

Behaviour:
- Reset values (all outputs and state):
  - State IDLE; busy 0; read_enable 0; read_row 0; read_col 0.
  - character_valid 0; character_last 0; character_byte/row/col 0.
  - Buffer occupancy 0; in-flight flag 0.
- State IDLE:
  - frame_start=1 -> READING next cycle; read address counters cleared to (0,0).
  - frame_start in any other state is ignored, with no effect on counters.
- State READING:
  - read_enable is combinational: high when free>0, where free = 2 - occupancy - inflight + pop.
  - pop = character_valid & character_ready in this cycle.
  - read_row/read_col present the current address.
  - On each issued read, the address advances: col+1; at col==COLS-1, col->0 and row+1.
  - On issuing address (ROWS-1, COLS-1) -> DRAINING next cycle.
- Read data capture:
  - The inflight register is set in the cycle after each issued read.
  - During that cycle, read_byte is written into the buffer tail together with the issue-time row/col and last flag.
- Buffer:
  - 2-entry FIFO; head drives the character_* outputs, which are registered.
  - Push and pop may occur in the same cycle; occupancy is then unchanged.
  - Credits guarantee no overflow; an overflow condition is a design error (assertion in bench).
- State DRAINING:
  - No reads issued.
  - On the handshake of the entry with character_last=1 -> IDLE next cycle; busy falls that same next cycle.
- Latency, with frame_start high in cycle 0:
  - read_enable=1 with (0,0) in cycle 1.
  - read_byte sampled in cycle 2.
  - character_valid=1 with (0,0) in cycle 3.
- Throughput: with character_ready held high, one character per cycle and no bubbles. A full frame completes its last handshake at cycle ROWS*COLS+2.
- Handshake rules:
  - character_valid, once high, stays high and its data stable until the handshake.
  - Outputs never depend combinationally on character_ready.
- Reset mid-operation:
  - Returns to IDLE immediately.
  - Buffer and inflight are cleared; read_byte in the following cycle is not captured.
  - character_valid drops the cycle after reset is sampled.
- Degenerate sizes:
  - ROWS=1 or COLS=1 must work.
  - With ROWS=1, COLS=1: a single read, and the single character carries character_last=1.

Test Plan:
1. Default params, character_ready=1, RAM model byte=(row*COLS+col)[7:0], frame_start at cycle 0 -> read_enable at cycle 1; first output (0,0) byte 0x00 at cycle 3; 3000 contiguous characters in raster order; last is (29,99) byte 0xB7 with character_last=1 at cycle 3002; busy falls at cycle 3003.
2. Backpressure: character_ready low for cycles 3-10 -> occupancy reaches 2; read_enable stays low; outputs (0,0) held stable. On release, order resumes (0,1),(0,2)… with no loss or duplication.
3. Random character_ready (50%) over a full frame -> 3000 characters exactly once, in order, with data/tag matching the RAM model; no buffer overflow assertion.
4. frame_start pulsed at cycles 0 and 500 -> second pulse ignored; exactly one frame of 3000 characters. frame_start after busy falls starts a new frame from (0,0).
5. Reset asserted at cycle 40 mid-frame with a read in flight -> character_valid 0 from cycle 41, busy 0, no stale capture. A new frame_start restarts from (0,0).
6. ROWS=2, COLS=3, ready high -> sequence (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); character_last only on (1,2). ROWS=1, COLS=1 -> single character with last=1.
